// File: rtl/exec_cont_if.sv
// Bundle of signals between the execute controller, the fetch controller
// and the data memory. The execute controller takes the master side:
// it drives the fetch request and the memory address/write port, and it
// receives the instruction fields and the memory read data.
interface exec_cont_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    // Fetch side
    logic          fetch_en;
    logic          ins_ready;
    logic          ins_finished;
    logic [1:0]    opcode;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic [AW-1:0] dst;

    // Data memory side (read data has one cycle of latency)
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_we;
    logic [DW-1:0] dm_rdata;

    modport master (
        output fetch_en, dm_addr, dm_wdata, dm_we,
        input  ins_ready, ins_finished, opcode, src1, src2, dst, dm_rdata
    );

    modport slave (
        input  fetch_en, dm_addr, dm_wdata, dm_we,
        output ins_ready, ins_finished, opcode, src1, src2, dst, dm_rdata
    );
endinterface

// File: rtl/exec_cont.sv
// Execute controller. Requests one instruction from fetch, reads both
// operands from data memory, computes add/sub/mul modulo 2^DW and writes
// the result back to dst. Halts on opcode 00 or on fetch's finished flag;
// only reset leaves the halted state.
// Optional feature macro: EXEC_OVF_EN adds a sticky overflow output that
// flags add carry-out, sub borrow and mul results wider than DW bits.
module exec_cont #(
    parameter int DATA_MEMORY_SIZE = 64,
    parameter int DATA_WIDTH       = 8,
    parameter int CNT_WIDTH        = 8,
    localparam int AW = $clog2(DATA_MEMORY_SIZE),
    localparam int DW = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    exec_cont_if.master          bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] instr_count
`ifdef EXEC_OVF_EN
    ,
    output logic                 overflow
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_RD1, S_RD2, S_EX, S_WB, S_HALT
    } state_t;

    state_t               state_reg, state_next;
    logic [1:0]           op_reg;
    logic [AW-1:0]        src1_reg, src2_reg, dst_reg;
    logic [DW-1:0]        a_reg, r_reg;
    logic [CNT_WIDTH-1:0] count_reg;
    logic                 accept;
    logic [DW-1:0]        alu_result;

    // A non-halt instruction is taken only while waiting, and a finished
    // indication in the same cycle wins over it.
    assign accept = (state_reg == S_WAIT) && bus.ins_ready && !bus.ins_finished
                    && (bus.opcode != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_REQ;
            S_REQ:  state_next = S_WAIT;
            S_WAIT: begin
                if (bus.ins_finished || (bus.ins_ready && bus.opcode == 2'b00))
                    state_next = S_HALT;
                else if (accept)
                    state_next = S_RD1;
            end
            S_RD1:  state_next = S_RD2;
            S_RD2:  state_next = S_EX;
            S_EX:   state_next = S_WB;
            S_WB:   state_next = S_REQ;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        bus.fetch_en = (state_reg == S_REQ);
        bus.dm_we    = (state_reg == S_WB);
        bus.dm_wdata = (state_reg == S_WB) ? r_reg : '0;
        bus.dm_addr  = '0;
        case (state_reg)
            S_RD1:   bus.dm_addr = src1_reg;
            S_RD2:   bus.dm_addr = src2_reg;
            S_WB:    bus.dm_addr = dst_reg;
            default: bus.dm_addr = '0;
        endcase
        busy = (state_reg != S_IDLE) && (state_reg != S_HALT);
        done = (state_reg == S_HALT);
    end

    // ALU: B is the read data arriving in EX, used directly so R is ready for WB
    always_comb begin
        alu_result = a_reg;
        case (op_reg)
            2'b01:   alu_result = a_reg + bus.dm_rdata;
            2'b10:   alu_result = a_reg - bus.dm_rdata;
            2'b11:   alu_result = a_reg * bus.dm_rdata;
            default: alu_result = a_reg;
        endcase
    end

    // Instruction fields, operand A, result and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg    <= '0;
            src1_reg  <= '0;
            src2_reg  <= '0;
            dst_reg   <= '0;
            a_reg     <= '0;
            r_reg     <= '0;
            count_reg <= '0;
        end else begin
            if (accept) begin
                op_reg   <= bus.opcode;
                src1_reg <= bus.src1;
                src2_reg <= bus.src2;
                dst_reg  <= bus.dst;
            end
            if (state_reg == S_RD2) a_reg <= bus.dm_rdata;
            if (state_reg == S_EX)  r_reg <= alu_result;
            if (state_reg == S_WB)  count_reg <= count_reg + CNT_WIDTH'(1);
        end
    end

    assign instr_count = count_reg;

`ifdef EXEC_OVF_EN
    logic          ovf_reg;
    logic          alu_ovf;
    logic [DW:0]   sum_wide;
    logic [2*DW-1:0] prod_wide;

    // Out-of-range detection for the operation being executed
    always_comb begin
        sum_wide  = {1'b0, a_reg} + {1'b0, bus.dm_rdata};
        prod_wide = {{DW{1'b0}}, a_reg} * {{DW{1'b0}}, bus.dm_rdata};
        alu_ovf   = 1'b0;
        case (op_reg)
            2'b01:   alu_ovf = (sum_wide >> DW) != '0;
            2'b10:   alu_ovf = (a_reg < bus.dm_rdata);
            2'b11:   alu_ovf = (prod_wide >> DW) != '0;
            default: alu_ovf = 1'b0;
        endcase
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)                            ovf_reg <= 1'b0;
        else if (state_reg == S_EX && alu_ovf) ovf_reg <= 1'b1;
    end

    assign overflow = ovf_reg;
`endif

endmodule
